// File: rtl/imm_operand_encoder_pkg.sv
// imm_operand_encoder_pkg: immediate type codes, pipeline payloads and range helper
package imm_operand_encoder_pkg;
  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    ITYPE = 3'd1,
    STYPE = 3'd2,
    BTYPE = 3'd3,
    UTYPE = 3'd4,
    JTYPE = 3'd5
  } imm_type_e;
  typedef struct packed {
    logic [31:0] base;
    logic [31:0] imm;
    logic [2:0]  typ;
  } enc_req_t;
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_rsp_t;
  function automatic logic fits_signed(logic [31:0] v, int bits);
    logic [31:0] s;
    s = 32'($signed(v) >>> (bits - 1));
    return s == '0 || s == '1;
  endfunction
endpackage

// File: rtl/imm_operand_encoder_if.sv
// imm_operand_encoder_if: request/response stream and error counter bundle
interface imm_operand_encoder_if #(parameter int ERR_CNT_W = 16);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_base;
  logic [31:0]          in_imm;
  logic [2:0]           in_type;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_cnt_clr;
  modport slave (
    input  in_valid, in_base, in_imm, in_type, out_ready, err_cnt_clr,
    output in_ready, out_valid, out_instr, out_err, err_cnt
  );
  modport master (
    output in_valid, in_base, in_imm, in_type, out_ready, err_cnt_clr,
    input  in_ready, out_valid, out_instr, out_err, err_cnt
  );
endinterface

// File: rtl/imm_operand_encoder_packer.sv
// imm_field_packer: scatters an immediate into its RV32I field positions and range-checks it
module imm_field_packer
  import imm_operand_encoder_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [2:0]  typ,
  output logic [31:0] instr,
  output logic        err
);
  logic [31:0] packed_w;
  logic        ok;
  // pick field layout and legality by type; unrepresentable values leave the base untouched
  always_comb begin
    packed_w = base;
    ok = 1'b0;
    case (typ)
      RTYPE: ok = imm == '0;
      ITYPE: begin
        packed_w = {imm[11:0], base[19:0]};
        ok = fits_signed(imm, 12);
      end
      STYPE: begin
        packed_w = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        ok = fits_signed(imm, 12);
      end
      BTYPE: begin
        packed_w = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        ok = fits_signed(imm, 13) && !imm[0];
      end
      UTYPE: begin
        packed_w = {imm[31:12], base[11:0]};
        ok = imm[11:0] == '0;
      end
      JTYPE: begin
        packed_w = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        ok = fits_signed(imm, 21) && !imm[0];
      end
      default: ok = 1'b0;
    endcase
    instr = ok ? packed_w : base;
    err = !ok;
  end
endmodule

// File: rtl/imm_operand_encoder.sv
// imm_operand_encoder: 2-stage valid/ready pipeline packing immediates into RV32I instructions
module imm_operand_encoder
  import imm_operand_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  imm_operand_encoder_if.slave bus
);
  enc_req_t             s1;
  enc_rsp_t             s2;
  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_adv;
  logic [31:0]          pk_instr;
  logic                 pk_err;
  logic [ERR_CNT_W-1:0] cnt;
  assign s1_adv        = !s2_valid || bus.out_ready;
  assign bus.in_ready  = !s1_valid || s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2.instr;
  assign bus.out_err   = s2.err;
  assign bus.err_cnt   = cnt;
  imm_field_packer u_packer (
    .base  (s1.base),
    .imm   (s1.imm),
    .typ   (s1.typ),
    .instr (pk_instr),
    .err   (pk_err)
  );
  // stage 1 captures the raw request whenever it has room
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1 <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1 <= '{base: bus.in_base, imm: bus.in_imm, typ: bus.in_type};
    end
  // stage 2 holds the packed result until downstream takes it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s2_valid <= 1'b0;
      s2 <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2 <= '{instr: pk_instr, err: pk_err};
    end
  // saturating count of delivered error beats; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (bus.err_cnt_clr) cnt <= '0;
    else if (s2_valid && bus.out_ready && s2.err && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: tb/tb_imm_operand_encoder.sv
// tb_imm_operand_encoder: scoreboard bench with random stimulus against a range-rule model
module tb_imm_operand_encoder;
  import imm_operand_encoder_pkg::*;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  imm_operand_encoder_if #(.ERR_CNT_W(W)) bus ();
  imm_operand_encoder #(.ERR_CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  enc_rsp_t q[$];
  int cyc_q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int mdl_err = 0;
  bit rnd_bp = 0;
  always @(posedge clk) cyc++;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic check1(string name, logic act, logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  function automatic enc_rsp_t model(logic [31:0] base, logic [31:0] imm, logic [2:0] t);
    longint v;
    bit ok;
    logic [31:0] r;
    v = $signed(imm);
    r = base;
    case (t)
      3'd0: ok = imm == 0;
      3'd1: begin ok = v >= -2048 && v <= 2047; r = {imm[11:0], base[19:0]}; end
      3'd2: begin ok = v >= -2048 && v <= 2047; r = {imm[11:5], base[24:12], imm[4:0], base[6:0]}; end
      3'd3: begin ok = v >= -4096 && v <= 4094 && !imm[0]; r = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]}; end
      3'd4: begin ok = (imm % 4096) == 0; r = {imm[31:12], base[11:0]}; end
      3'd5: begin ok = v >= -1048576 && v <= 1048574 && !imm[0]; r = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]}; end
      default: ok = 0;
    endcase
    return '{instr: ok ? r : base, err: !ok};
  endfunction
  always @(negedge clk) begin
    enc_rsp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out: got 0x%0h expected no beat", bus.out_instr);
      end else begin
        e = q.pop_front();
        check("out_instr", bus.out_instr, e.instr);
        check1("out_err", bus.out_err, e.err);
        if (e.err) mdl_err++;
        cyc_q.push_back(cyc);
      end
    end
  end
  always @(posedge clk) if (rnd_bp) #1 bus.out_ready = 1'($urandom_range(0, 1));
  task automatic send(logic [31:0] b, logic [31:0] i, logic [2:0] t, enc_rsp_t e);
    logic rdy;
    bus.in_base = b;
    bus.in_imm = i;
    bus.in_type = t;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        q.push_back(e);
        #1 bus.in_valid = 1'b0;
        return;
      end
      #1;
    end
    compared++;
    mismatched++;
    $display("FAIL send_timeout: got in_ready=0 expected acceptance");
    bus.in_valid = 1'b0;
  endtask
  task automatic send_m(logic [31:0] b, logic [31:0] i, logic [2:0] t);
    send(b, i, t, model(b, i, t));
  endtask
  task automatic drain();
    for (int n = 0; n < 500 && q.size() != 0; n++) @(negedge clk);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic clr_pulse();
    @(posedge clk);
    #1 bus.err_cnt_clr = 1'b1;
    @(posedge clk);
    #1 bus.err_cnt_clr = 1'b0;
    mdl_err = 0;
  endtask
  initial begin
    logic [31:0] imm;
    int x;
    bus.in_valid = 1'b0;
    bus.in_base = '0;
    bus.in_imm = '0;
    bus.in_type = '0;
    bus.out_ready = 1'b1;
    bus.err_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check1("rst_out_err", bus.out_err, 1'b0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check1("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(32'h00000093, 32'hFFFFFFFF, ITYPE, '{instr: 32'hFFF00093, err: 1'b0});
    @(negedge clk);
    check1("lat1_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    check1("lat2_out_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    send(32'h0020A023, 32'd8, STYPE, '{instr: 32'h0020A423, err: 1'b0});
    send(32'h00000063, 32'hFFFFFFFC, BTYPE, '{instr: 32'hFE000EE3, err: 1'b0});
    send(32'h000000EF, 32'h00000800, JTYPE, '{instr: 32'h001000EF, err: 1'b0});
    send(32'h000002B7, 32'h12345000, UTYPE, '{instr: 32'h123452B7, err: 1'b0});
    drain();
    rnd_bp = 1;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: begin x = int'($urandom_range(0, 12287)) - 6144; imm = x; end
        2: begin x = int'($urandom_range(0, 4194303)) - 2097152; imm = x; end
        default: imm = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFFF000) : 32'h0;
      endcase
      if ($urandom_range(0, 1) != 0) imm[0] = 1'b0;
      send_m($urandom, imm, 3'($urandom_range(0, 7)));
    end
    rnd_bp = 0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain();
    check("rand_err_cnt", 32'(bus.err_cnt), 32'(mdl_err));
    clr_pulse();
    check("clr_err_cnt", 32'(bus.err_cnt), 32'h0);
    send(32'h00000063, 32'd3, BTYPE, '{instr: 32'h00000063, err: 1'b1});
    send(32'h00000093, 32'd2048, ITYPE, '{instr: 32'h00000093, err: 1'b1});
    send(32'h000002B7, 32'h12345001, UTYPE, '{instr: 32'h000002B7, err: 1'b1});
    send(32'h12345678, 32'h0, 3'b111, '{instr: 32'h12345678, err: 1'b1});
    drain();
    check("err_cnt_four", 32'(bus.err_cnt), 32'd4);
    clr_pulse();
    check("err_cnt_cleared", 32'(bus.err_cnt), 32'h0);
    bus.out_ready = 1'b0;
    send(32'h00000063, 32'd3, BTYPE, '{instr: 32'h00000063, err: 1'b1});
    @(negedge clk);
    @(negedge clk);
    check1("clrwin_out_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.err_cnt_clr = 1'b1;
    @(posedge clk);
    #1 bus.err_cnt_clr = 1'b0;
    mdl_err = 0;
    check("clr_wins", 32'(bus.err_cnt), 32'h0);
    drain();
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'h00000013, 32'd5, ITYPE, '{instr: 32'h00500013, err: 1'b0});
        send(32'h0020A023, 32'd8, STYPE, '{instr: 32'h0020A423, err: 1'b0});
        send(32'h000000EF, 32'h00000800, JTYPE, '{instr: 32'h001000EF, err: 1'b0});
      end
    join_none
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1("bp_in_ready", bus.in_ready, 1'b0);
      check1("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_out_stable", bus.out_instr, 32'h00500013);
    end
    check("bp_accepted", 32'(q.size()), 32'd2);
    @(posedge clk);
    #1;
    cyc_q.delete();
    bus.out_ready = 1'b1;
    drain();
    check("bp_beats_out", 32'(cyc_q.size()), 32'd3);
    if (cyc_q.size() == 3) begin
      check("bp_gap0", 32'(cyc_q[1] - cyc_q[0]), 32'd1);
      check("bp_gap1", 32'(cyc_q[2] - cyc_q[1]), 32'd1);
    end
    bus.out_ready = 1'b0;
    send(32'h00000093, 32'd1, ITYPE, '{instr: 32'h00100093, err: 1'b0});
    send(32'h00000093, 32'd2, ITYPE, '{instr: 32'h00200093, err: 1'b0});
    @(negedge clk);
    check1("pre_rst_out_valid", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("async_rst_out_valid", bus.out_valid, 1'b0);
    check("async_rst_instr", bus.out_instr, 32'h0);
    q.delete();
    mdl_err = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    send(32'h000002B7, 32'hABCDE000, UTYPE, '{instr: 32'hABCDE2B7, err: 1'b0});
    @(negedge clk);
    check1("post_rst_lat1", bus.out_valid, 1'b0);
    @(negedge clk);
    check1("post_rst_lat2", bus.out_valid, 1'b1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end
endmodule
